// File: rtl/sha256_msg_sched_if.sv
// Bundle of the two handshakes around the SHA-256 message schedule expander:
// the padded-block input from the padder and the schedule-word output to the
// round engine.
//
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid && ready are both high. Once raised, valid and its payload stay
// stable until that transfer. A ready seen while valid is low has no effect.
interface sha256_msg_sched_if;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         w_valid;
  logic         w_ready;
  logic [31:0]  w_data;
  logic [5:0]   w_idx;
  logic         w_last;

  // Expander-side view: consumes blocks, produces words.
  modport slave (
    input  blk_valid, blk_data, w_ready,
    output blk_ready, w_valid, w_data, w_idx, w_last
  );

  // Environment-side view: supplies blocks, consumes words.
  modport master (
    output blk_valid, blk_data, w_ready,
    input  blk_ready, w_valid, w_data, w_idx, w_last
  );
endinterface

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule expander.
// Accepts one padded 512-bit block and emits W0..W63, one word per handshake.
// W0..W15 are the big-endian block words; W16..W63 are produced on the fly in
// a 16-word sliding window, so the window head is always the word on output.
module sha256_msg_sched (
  input  logic                clk,
  input  logic                rst_n,
  sha256_msg_sched_if.slave   bus,
  output logic                state_dbg   // 0 = IDLE, 1 = EMIT
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];
  logic [5:0]  t_q, t_d;
  logic        w_valid_q, w_valid_d;
  logic [31:0] w_next;
  logic        w_xfer;

  // Small sigma functions of the schedule recurrence.
  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Word that enters the window tail: with win[0] = W_t this is W_{t+16}.
  // Computed every cycle; values produced for t >= 48 are never shifted out.
  always_comb begin
    w_next = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
  end

  // Output-side transfer qualifier.
  always_comb begin
    w_xfer = w_valid_q && bus.w_ready;
  end

  // Next-state logic: block load in IDLE, shift/advance on each word transfer.
  always_comb begin
    state_d   = state_q;
    t_d       = t_q;
    w_valid_d = w_valid_q;
    for (int i = 0; i < 16; i++) begin
      win_d[i] = win_q[i];
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.blk_valid) begin
          for (int i = 0; i < 16; i++) begin
            win_d[i] = bus.blk_data[511 - 32*i -: 32];
          end
          t_d       = 6'd0;
          w_valid_d = 1'b1;
          state_d   = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (w_xfer) begin
          if (t_q == 6'd63) begin
            t_d       = 6'd0;
            w_valid_d = 1'b0;
            state_d   = ST_IDLE;
          end else begin
            for (int i = 0; i < 15; i++) begin
              win_d[i] = win_q[i + 1];
            end
            win_d[15] = w_next;
            t_d       = t_q + 6'd1;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        t_d       = 6'd0;
        w_valid_d = 1'b0;
      end
    endcase
  end

  // State, window, round index and valid registers; reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      t_q       <= 6'd0;
      w_valid_q <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= 32'd0;
      end
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      w_valid_q <= w_valid_d;
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

  // Outputs come straight from registers; blk_ready depends only on state.
  always_comb begin
    bus.blk_ready = (state_q == ST_IDLE);
    bus.w_valid   = w_valid_q;
    bus.w_data    = win_q[0];
    bus.w_idx     = t_q;
    bus.w_last    = (t_q == 6'd63) && w_valid_q;
    state_dbg     = state_q;
  end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Bench for the SHA-256 message schedule expander: directed sequence of block
// runs with random payloads and random output backpressure, scored against a
// plain 64-entry array expansion of the schedule recurrence.
module tb_sha256_msg_sched;

  logic clk;
  logic rst_n;
  logic state_dbg;

  sha256_msg_sched_if bus ();

  sha256_msg_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q [$];
  logic [31:0] obs_w [64];
  logic [31:0] abc_w [64];

  localparam logic [511:0] ABC_BLK = {32'h61626380, {14{32'h0}}, 32'h00000018};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: full 64-word array expansion straight from the recurrence.
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic load_ref(input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] s0, s1;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0   = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
      s1   = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    for (int t = 0; t < 64; t++) exp_q.push_back(w[t]);
  endtask

  function automatic logic [511:0] rand_blk();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  // Driver: present a block for one accepting edge (called at a negedge).
  task automatic start_block(input logic [511:0] blk);
    check("blk_ready_idle", bus.blk_ready, 1);
    bus.blk_valid = 1'b1;
    bus.blk_data  = blk;
    @(posedge clk); @(negedge clk);
    bus.blk_valid = 1'b0;
    check("state_emit", state_dbg, 1);
  endtask

  // Driver + monitor: consume n words with ready duty pct, scoring each.
  task automatic drain(input int n, input int pct, input bit pulse);
    int          k = 0;
    int          cyc = 0;
    bit          stalled = 0;
    bit          pulsed = 0;
    logic [31:0] pd = '0;
    logic [5:0]  pi = '0;
    while (k < n && cyc < 4000) begin
      if (stalled) begin
        check("stall_data", bus.w_data, pd);
        check("stall_idx", bus.w_idx, pi);
      end
      check("w_valid", bus.w_valid, 1);
      check("blk_ready_emit", bus.blk_ready, 0);
      check("w_idx", bus.w_idx, k);
      check("w_last", bus.w_last, (k == 63));
      if (exp_q.size() == 0) check("exp_q_empty", 1, 0);
      else check("w_data", bus.w_data, exp_q[0]);
      if (pulse) begin
        if (k == 10 && !pulsed) begin
          bus.blk_valid = 1'b1;
          bus.blk_data  = rand_blk();
          pulsed        = 1;
        end else begin
          bus.blk_valid = 1'b0;
        end
      end
      bus.w_ready = ($urandom_range(0, 99) < pct);
      pd = bus.w_data;
      pi = bus.w_idx;
      stalled = !bus.w_ready;
      if (bus.w_ready) begin
        obs_w[k] = bus.w_data;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        k++;
      end
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    bus.w_ready = 1'b0;
    if (pulse) bus.blk_valid = 1'b0;
    check("drain_in_budget", (cyc < 4000), 1);
  endtask

  task automatic check_done();
    check("done_w_valid", bus.w_valid, 0);
    check("done_blk_ready", bus.blk_ready, 1);
    check("done_w_last", bus.w_last, 0);
    check("done_state", state_dbg, 0);
  endtask

  initial begin
    logic [511:0] b1, b2;
    rst_n         = 1'b0;
    bus.blk_valid = 1'b0;
    bus.blk_data  = '0;
    bus.w_ready   = 1'b0;

    // Reset values
    #3;
    check("rst_w_valid", bus.w_valid, 0);
    check("rst_w_data", bus.w_data, 0);
    check("rst_w_idx", bus.w_idx, 0);
    check("rst_w_last", bus.w_last, 0);
    check("rst_blk_ready", bus.blk_ready, 1);
    check("rst_state", state_dbg, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // "abc" block with w_ready held high
    load_ref(ABC_BLK);
    start_block(ABC_BLK);
    drain(64, 100, 0);
    check_done();
    check("abc_w0",  obs_w[0],  32'h61626380);
    check("abc_w15", obs_w[15], 32'h00000018);
    check("abc_w16", obs_w[16], 32'h61626380);
    check("abc_w17", obs_w[17], 32'h000F0000);
    check("abc_w18", obs_w[18], 32'h7DA86405);
    check("abc_w19", obs_w[19], 32'h600003C6);
    for (int i = 0; i < 64; i++) abc_w[i] = obs_w[i];

    // All-zero block
    load_ref('0);
    start_block('0);
    drain(64, 100, 0);
    check_done();
    for (int i = 0; i < 64; i += 9) check("zero_word", obs_w[i], 0);

    // "abc" under ~30% ready duty: same sequence as the unstalled run
    load_ref(ABC_BLK);
    start_block(ABC_BLK);
    drain(64, 30, 0);
    check_done();
    for (int i = 0; i < 64; i++) check("bp_same_as_free", obs_w[i], abc_w[i]);

    // Random block with random backpressure
    b1 = rand_blk();
    load_ref(b1);
    start_block(b1);
    drain(64, 60, 0);
    check_done();

    // Back-to-back blocks with blk_valid held high
    b1 = rand_blk();
    b2 = rand_blk();
    load_ref(b1);
    bus.blk_valid = 1'b1;
    bus.blk_data  = b1;
    @(posedge clk); @(negedge clk);
    drain(64, 100, 0);
    check("b2b_gap_w_valid", bus.w_valid, 0);
    check("b2b_gap_blk_ready", bus.blk_ready, 1);
    load_ref(b2);
    bus.blk_data = b2;
    @(posedge clk); @(negedge clk);
    bus.blk_valid = 1'b0;
    check("b2b_second_w0", bus.w_data, b2[511:480]);
    drain(64, 100, 0);
    check_done();

    // blk_valid pulsed during EMIT is ignored
    b1 = rand_blk();
    load_ref(b1);
    start_block(b1);
    drain(64, 80, 1);
    check_done();

    // Reset while w_idx = 20
    b1 = rand_blk();
    load_ref(b1);
    start_block(b1);
    drain(20, 100, 0);
    check("pre_rst_idx", bus.w_idx, 20);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_w_valid", bus.w_valid, 0);
    check("async_rst_blk_ready", bus.blk_ready, 1);
    check("async_rst_w_idx", bus.w_idx, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    b2 = rand_blk();
    load_ref(b2);
    start_block(b2);
    drain(64, 70, 0);
    check_done();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sha256_msg_sched.md
Name: sha256_msg_sched

Overview:
SHA-256 message schedule expander. Sits directly downstream of the byte-to-block padder: it accepts one padded 512-bit block over a valid/ready handshake and emits the 64 schedule words W0..W63, one per handshake, to the compression round engine. W0..W15 are the block words, taken big-endian. W16..W63 are computed in a 16-word sliding window, so the block needs no 64-word storage.

Parameters:
none (64 rounds and 32-bit words are fixed by FIPS 180-4)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
blk_valid  input  1  padded block available from upstream
blk_ready  output  1  block slot free; high only in IDLE
blk_data  input  512  padded block; byte 0 of message in [511:504]
w_valid  output  1  schedule word valid
w_ready  input  1  round engine accepts word
w_data  output  32  schedule word W_t
w_idx  output  6  round index t of w_data
w_last  output  1  high with w_valid when t = 63

Behaviour:
- One clock domain: clk. Reset is asynchronous, active-low, on rst_n.
- States: IDLE, EMIT.
- Reset values: state=IDLE, window regs win[0..15]=0, t=0, w_valid=0. Consequences: w_data=0, w_idx=0, w_last=0, blk_ready=1.
- blk_ready = (state==IDLE), combinational. It does not depend on w_ready.
- IDLE: on blk_valid&&blk_ready:
  - win[i] <= blk_data[511-32i -: 32] for i=0..15.
  - t <= 0; w_valid <= 1; state <= EMIT.
  - First word is visible the cycle after block acceptance (latency 1).
- EMIT:
  - w_data = win[0], w_idx = t; w_last = (t==63) && w_valid.
  - Outputs are held stable while w_valid && !w_ready.
  - On w_valid&&w_ready with t<63:
    - win[i] <= win[i+1] for i=0..14.
    - win[15] <= sig1(win[14]) + win[9] + sig0(win[1]) + win[0], mod 2^32.
    - t <= t+1.
    - The computed value equals W_{t+16}. It is computed unconditionally; values computed for t>=48 are never emitted, which is harmless.
  - On handshake with t==63: w_valid <= 0; state <= IDLE; t <= 0. blk_ready rises the next cycle.
- Sigma functions:
  - sig0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x)
  - sig1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x)
- Throughput: one word per cycle when w_ready is held high. 64 EMIT cycles plus 1 IDLE cycle per block, so the next block is accepted 65 cycles after the previous one.
- w_ready low: no shift, no t change, no compute side effects.
- blk_valid is ignored outside IDLE. Upstream holds its block; no data is lost.
- w_ready asserted while w_valid=0: no effect.
- Reset mid-block: all state returns to reset values immediately, and the partial block is discarded. After release, blk_ready=1.
- No combinational path from w_ready to w_valid or w_data. blk_ready depends only on state.

Test Plan:
- "abc" padded block (0x61626380, then 14 zero words, then 0x00000018), w_ready=1:
  - W0=61626380, W15=00000018, W16=61626380, W17=000F0000, W18=7DA86405, W19=600003C6.
  - w_last only at w_idx=63.
  - All 64 words match a software model.
- All-zero block: all 64 words are 00000000; w_idx runs 0..63 contiguously; blk_ready=0 throughout EMIT.
- Backpressure: random w_ready duty (about 30%) on the "abc" block:
  - the emitted word sequence is identical to the w_ready=1 run;
  - w_data and w_idx are stable during every stall cycle.
- Back-to-back blocks with blk_valid held high:
  - the second block is accepted exactly 1 cycle after the W63 handshake;
  - its W0 is correct, with no carry-over from the previous block's window.
- Reset asserted while w_idx=20:
  - w_valid=0 and blk_ready=1 asynchronously;
  - after release, a new block restarts cleanly at w_idx=0 with correct words.
- blk_valid pulsed during EMIT: the block is not accepted; emission continues unchanged.
